// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file: registered write-first reads plus a sequential bulk-clear engine.
// Optional build macro REGFILE_ZERO_REG_EN hard-wires register 0 to zero.
module regfile_2w2r #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  wr_drop
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    state_t                           state, state_nxt;
    logic [ADDR_WIDTH-1:0]            clr_ptr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem, mem_nxt;
    wr_req_t                          wr0, wr1;

    // User writes are discarded while the clear engine owns the array.
    always_comb begin
        wr0.en   = we0 & ~busy & ~(ZERO_REG & (waddr0 == '0));
        wr0.addr = waddr0;
        wr0.data = wdata0;
        wr1.en   = we1 & ~busy & ~(ZERO_REG & (waddr1 == '0));
        wr1.addr = waddr1;
        wr1.data = wdata1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_ptr == '1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            clr_ptr <= '0;
        else if (state == IDLE && clr_req)  clr_ptr <= '0;
        else if (state == CLEAR)            clr_ptr <= clr_ptr + 1'b1;
    end

    // Post-edge array image; reads index it so same-cycle writes bypass naturally.
    always_comb begin
        mem_nxt = mem;
        if (busy) mem_nxt[clr_ptr] = '0;
        if (wr0.en) mem_nxt[wr0.addr] = wr0.data;
        if (wr1.en) mem_nxt[wr1.addr] = wr1.data;
        if (ZERO_REG) mem_nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            rdata1  <= '0;
            rdata2  <= '0;
            wr_drop <= 1'b0;
        end else begin
            mem     <= mem_nxt;
            rdata1  <= mem_nxt[raddr1];
            rdata2  <= mem_nxt[raddr2];
            wr_drop <= busy & (we0 | we1);
        end
    end
endmodule

// File: tb/tb_regfile_2w2r.sv
// Randomised self-checking bench for regfile_2w2r against an array-based reference model.
module tb_regfile_2w2r;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] waddr0 = '0, waddr1 = '0, raddr1 = '0, raddr2 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [DW-1:0] rdata1, rdata2;
    logic          busy, clr_done, wr_drop;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array plus a count of clear cycles still owed.
    logic [DW-1:0] m [DEPTH];
    int            clr_left = 0, clr_pos = 0;
    logic [DW-1:0] exp_rd1, exp_rd2;
    bit            exp_busy = 0, exp_done = 0, exp_drop = 0;

    regfile_2w2r #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        clr_left = 0; clr_pos = 0;
        exp_rd1 = '0; exp_rd2 = '0;
        exp_busy = 0; exp_done = 0; exp_drop = 0;
    endtask

    // Apply current inputs for one edge, advance the model, sample 1 time unit later.
    task automatic step();
        bit was_busy = (clr_left > 0);
        bit in_done  = exp_done;
        exp_drop = was_busy && (we0 || we1);
        exp_done = 0;
        if (was_busy) begin
            m[clr_pos] = '0;
            clr_pos = (clr_pos + 1) % DEPTH;
            clr_left--;
            if (clr_left == 0) exp_done = 1;
        end else begin
            if (we0 && !(ZR && waddr0 == 0)) m[waddr0] = wdata0;
            if (we1 && !(ZR && waddr1 == 0)) m[waddr1] = wdata1;
            if (clr_req && !in_done) begin clr_left = DEPTH; clr_pos = 0; end
        end
        exp_busy = (clr_left > 0);
        exp_rd1 = m[raddr1];
        exp_rd2 = m[raddr2];
        @(posedge clk); #1;
        we0 = 0; we1 = 0; clr_req = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1; #1;
        model_reset();
        checks++; if (rdata1 !== '0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
        checks++; if (rdata2 !== '0) begin errors++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
        checks++; if ({busy, clr_done, wr_drop} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {busy, clr_done, wr_drop});
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic();
        raddr1 = 0; raddr2 = 1;
        we0 = 1; waddr0 = 0; wdata0 = 16'hAAAA; step();
        we0 = 1; waddr0 = 1; wdata0 = 16'h5555; step();
        step();
        checks++; if (rdata1 !== (ZR ? 16'h0000 : 16'hAAAA)) begin errors++; $display("FAIL basic_rd1 got=%h", rdata1); end
        checks++; if (rdata2 !== 16'h5555) begin errors++; $display("FAIL basic_rd2 got=%h exp=5555", rdata2); end
    endtask

    task automatic test_dual_write();
        raddr1 = 3; raddr2 = 4;
        we0 = 1; waddr0 = 3; wdata0 = 16'h1111;
        we1 = 1; waddr1 = 3; wdata1 = 16'h2222; step();
        checks++; if (rdata1 !== 16'h2222) begin errors++; $display("FAIL dual_same_bypass got=%h exp=2222", rdata1); end
        raddr1 = 4; raddr2 = 5;
        we0 = 1; waddr0 = 4; wdata0 = 16'h0F0F;
        we1 = 1; waddr1 = 5; wdata1 = 16'hF0F0; step();
        raddr1 = 3; step();
        checks++; if (rdata1 !== 16'h2222) begin errors++; $display("FAIL dual_same_stored got=%h exp=2222", rdata1); end
        raddr1 = 4; step();
        checks++; if ({rdata1, rdata2} !== {16'h0F0F, 16'hF0F0}) begin
            errors++; $display("FAIL dual_diff got=%h/%h exp=0f0f/f0f0", rdata1, rdata2);
        end
    endtask

    task automatic test_bypass();
        we0 = 1; waddr0 = 2; wdata0 = 16'h1234; step();
        raddr1 = 2; raddr2 = 2;
        we0 = 1; waddr0 = 2; wdata0 = 16'hBEEF; step();
        checks++; if (rdata1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_p0 got=%h exp=beef", rdata1); end
        we0 = 1; waddr0 = 2; wdata0 = 16'h0001;
        we1 = 1; waddr1 = 2; wdata1 = 16'h0002; step();
        checks++; if (rdata2 !== 16'h0002) begin errors++; $display("FAIL bypass_p1_prio got=%h exp=0002", rdata2); end
    endtask

    task automatic test_clear();
        int nbusy = 0, ndone = 0;
        for (int i = 0; i < DEPTH; i += 2) begin
            we0 = 1; waddr0 = AW'(i);     wdata0 = DW'($urandom_range(1, 16'hFFFF));
            we1 = 1; waddr1 = AW'(i + 1); wdata1 = DW'($urandom_range(1, 16'hFFFF));
            step();
        end
        clr_req = 1; step();
        if (busy) nbusy++;
        for (int i = 0; i < DEPTH + 4; i++) begin
            raddr1 = AW'($urandom());
            raddr2 = AW'(i);
            if (i == 2) begin we0 = 1; waddr0 = 7; wdata0 = 16'hFFFF; end
            if (i == 5) clr_req = 1;
            if (clr_done) clr_req = 1;
            step();
            if (busy) nbusy++;
            if (clr_done) ndone++;
            checks++; if (rdata1 !== exp_rd1) begin errors++; $display("FAIL clear_rd1 i=%0d got=%h exp=%h", i, rdata1, exp_rd1); end
            checks++; if (rdata2 !== exp_rd2 || (i < DEPTH && rdata2 !== '0)) begin
                errors++; $display("FAIL clear_rd2 i=%0d got=%h exp=%h", i, rdata2, exp_rd2);
            end
            checks++; if ({busy, clr_done, wr_drop} !== {exp_busy, exp_done, exp_drop}) begin
                errors++; $display("FAIL clear_flags i=%0d got=%b exp=%b", i, {busy, clr_done, wr_drop}, {exp_busy, exp_done, exp_drop});
            end
            if (i == 2) begin
                checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL clear_wr_drop got=%b exp=1", wr_drop); end
            end
        end
        checks++; if (nbusy != DEPTH) begin errors++; $display("FAIL clear_busy_len got=%0d exp=%0d", nbusy, DEPTH); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL clear_done_pulses got=%0d exp=1", ndone); end
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i); raddr2 = 7; step();
            checks++; if ({rdata1, rdata2} !== '0) begin
                errors++; $display("FAIL clear_after addr=%0d got=%h/%h exp=0/0", i, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int ndone = 0;
        we0 = 1; waddr0 = 9; wdata0 = 16'hFFFF;
        we1 = 1; waddr1 = 12; wdata1 = 16'hA5A5; step();
        clr_req = 1; step();
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1; #1;
        model_reset();
        checks++; if ({busy, clr_done} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b exp=00", {busy, clr_done}); end
        @(negedge clk); rst = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            raddr1 = AW'(i); step();
            if (clr_done) ndone++;
            if (i < DEPTH) begin
                checks++; if (rdata1 !== '0) begin errors++; $display("FAIL midrst_zero addr=%0d got=%h exp=0", i, rdata1); end
            end
        end
        checks++; if (ndone != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_done done=%0d busy=%b", ndone, busy); end
        raddr1 = 9; we0 = 1; waddr0 = 9; wdata0 = 16'h1234; step();
        step();
        checks++; if (rdata1 !== 16'h1234) begin errors++; $display("FAIL midrst_write got=%h exp=1234", rdata1); end
    endtask

    task automatic test_zero_reg();
        raddr1 = 0; raddr2 = 0;
        we0 = 1; waddr0 = 0; wdata0 = 16'hFFFF; step();
        checks++; if (rdata1 !== (ZR ? 16'h0000 : 16'hFFFF)) begin errors++; $display("FAIL zero_p0 got=%h", rdata1); end
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL zero_wr_drop got=%b exp=0", wr_drop); end
        we1 = 1; waddr1 = 0; wdata1 = 16'h7777; step();
        step();
        checks++; if (rdata2 !== (ZR ? 16'h0000 : 16'h7777)) begin errors++; $display("FAIL zero_p1 got=%h", rdata2); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            we0 = ($urandom_range(0, 1) == 1); waddr0 = AW'($urandom()); wdata0 = DW'($urandom());
            we1 = ($urandom_range(0, 1) == 1); waddr1 = AW'($urandom()); wdata1 = DW'($urandom());
            raddr1 = AW'($urandom()); raddr2 = AW'($urandom());
            clr_req = ($urandom_range(0, 29) == 0);
            step();
            checks++; if (rdata1 !== exp_rd1) begin errors++; $display("FAIL rand_rd1 cyc=%0d got=%h exp=%h", i, rdata1, exp_rd1); end
            checks++; if (rdata2 !== exp_rd2) begin errors++; $display("FAIL rand_rd2 cyc=%0d got=%h exp=%h", i, rdata2, exp_rd2); end
            checks++; if ({busy, clr_done, wr_drop} !== {exp_busy, exp_done, exp_drop}) begin
                errors++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", i, {busy, clr_done, wr_drop}, {exp_busy, exp_done, exp_drop});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dual_write();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_zero_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised register file: 2 write ports, 2 registered read ports, write-first bypass, and a sequential bulk-clear engine.
- Next generation of the team's 16x16 register file, for the datapath's operand store.
- Adds configurable width and depth, a second write port, deterministic read latency and an in-service clear without a global reset.

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH registers.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_WIDTH  write address, port 0.
- wdata0  in  DATA_WIDTH  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_WIDTH  write address, port 1.
- wdata1  in  DATA_WIDTH  write data, port 1.
- raddr1  in  ADDR_WIDTH  read address, port 1.
- raddr2  in  ADDR_WIDTH  read address, port 2.
- rdata1  out  DATA_WIDTH  registered read data, port 1.
- rdata2  out  DATA_WIDTH  registered read data, port 2.
- clr_req  in  1  start bulk clear; sampled only in IDLE.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.
- wr_drop  out  1  one-cycle pulse: a write was discarded because busy.

Behaviour:
- Reset (async, rst=1): all DEPTH registers = 0, rdata1/2 = 0, busy = 0, clr_done = 0, wr_drop = 0, FSM = IDLE, clear pointer = 0. Reset mid-clear aborts the clear; no clr_done is issued.
- Writes: committed on rising clk when weN=1 and busy=0.
  - Both ports to the same address in one cycle: port 1 wins.
  - Different addresses: both committed.
- Reads: 1-cycle latency. rdataN after edge k = register contents at raddrN after edge k's writes (write-first).
  - Bypass: same-cycle write to raddrN returns that wdata, port 1 taking priority over port 0.
  - Reads are never blocked, including during clear.
- FSM states:
  - IDLE: busy=0. clr_req=1 at an edge -> CLEAR, pointer=0. A write in that same cycle is still accepted.
  - CLEAR: busy=1. Each cycle writes 0 to reg[pointer], pointer+1. After the write at pointer=DEPTH-1 -> DONE. Occupies exactly DEPTH cycles.
  - DONE: busy=0, clr_done=1 for this one cycle, writes accepted -> IDLE.
- Clear interactions:
  - clr_req in CLEAR or DONE is ignored and not queued.
  - Pointer wraps naturally at ADDR_WIDTH bits; it is reset to 0 on entry to CLEAR.
  - Read of the address being cleared in a cycle returns 0 (bypass applies to clear writes).
- wr_drop: registered; 1 in the cycle after any edge where busy=1 and (we0|we1)=1. Dropped data never reaches the array.
- Arithmetic: addresses unsigned; no out-of-range case (DEPTH is a full power of two).

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired to 0; writes to address 0 are ignored by both ports and by the bypass.
  - Reads of address 0 always return 0.
  - wr_drop is not asserted for address-0 writes when not busy.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset/basic: assert rst mid-cycle -> rdata1/2=0 immediately, busy=0. Write reg0=16'hAAAA, reg1=16'h5555 via port 0; raddr1=0, raddr2=1 -> next cycle rdata1=AAAA, rdata2=5555.
- Dual write: we0/we1 same cycle to addr 3 with 16'h1111/16'h2222 -> reg3=2222. Addr 4/5 with 16'h0F0F/16'hF0F0 -> both stored.
- Bypass: raddr1=2 while we0 writes 16'hBEEF to addr 2 -> rdata1=BEEF one cycle later, not the old value.
- Clear: preload all 16 regs non-zero, pulse clr_req -> busy=1 for exactly 16 cycles, then clr_done=1 for 1 cycle. All reads return 0 afterwards. we0 to addr 7 during busy -> wr_drop pulse, reg7 stays 0.
- Reset mid-clear: rst after 5 clear cycles -> busy=0, no clr_done, all regs 0. New write to addr 9 = 16'h1234 reads back 1234.
- REGFILE_ZERO_REG_EN: write 16'hFFFF to addr 0 -> rdata = 0 (with macro); rdata = FFFF (without).
